// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    // Which port owns the read data coming back from memory this cycle.
    typedef enum logic [1:0] {
        NONE   = 2'd0,
        IFETCH = 2'd1,
        DLOAD  = 2'd2
    } rsp_owner_t;

    // Access size encodings understood by the memory.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // A granted data access produces a response only when it is a load.
    function automatic logic is_load(input logic gnt, input logic we);
        return gnt & ~we;
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive data grants while a fetch is waiting and raises
// force_i once the streak reaches STARVE_MAX, so fetch cannot starve.
module arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req,
    input  logic       d_gnt,
    input  logic       i_gnt,
    output logic       force_i,
    output logic [3:0] streak
);

    localparam logic [3:0] STREAK_LIMIT = 4'(STARVE_MAX);

    logic [3:0] streak_nxt;

    // Next streak value: cleared when fetch is served or not waiting, saturating count otherwise.
    always_comb begin
        streak_nxt = streak;
        if (!i_req) begin
            streak_nxt = 4'd0;
        end else if (i_gnt) begin
            streak_nxt = 4'd0;
        end else if (d_gnt) begin
            if (streak >= STREAK_LIMIT) begin
                streak_nxt = STREAK_LIMIT;
            end else begin
                streak_nxt = streak + 4'd1;
            end
        end else begin
            streak_nxt = streak;
        end
    end

    // Streak register with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak <= 4'd0;
        end else begin
            streak <= streak_nxt;
        end
    end

    // Fetch must win once D has been granted STARVE_MAX times in a row while it waited.
    always_comb begin
        force_i = i_req & (streak == STREAK_LIMIT);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the shared byte-lane data memory between instruction fetch (I)
// and load/store (D). D has priority except when the starvation counter
// forces an I grant. One access per cycle; read data returns next cycle
// to whichever port issued it.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int SIZE_LOG2  = 13,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req,
    input  logic [SIZE_LOG2-1:0] i_addr,
    input  logic                 i_flush,
    output logic                 i_gnt,
    output logic                 i_rvalid,
    output logic [31:0]          i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [1:0]           d_size,
    input  logic                 d_signed,
    input  logic [SIZE_LOG2-1:0] d_addr,
    input  logic [31:0]          d_wdata,
    output logic                 d_gnt,
    output logic                 d_rvalid,
    output logic [31:0]          d_rdata,
    output logic                 mem_WE,
    output logic [1:0]           mem_MemSize,
    output logic                 mem_MemSigned,
    output logic [SIZE_LOG2-1:0] mem_A,
    output logic [31:0]          mem_WD,
    input  logic [31:0]          mem_RD
);

    logic       force_i;
    logic [3:0] streak;
    rsp_owner_t rsp_owner;
    logic       i_rvalid_r;
    logic       d_rvalid_r;

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .d_gnt   (d_gnt),
        .i_gnt   (i_gnt),
        .force_i (force_i),
        .streak  (streak)
    );

    // Grant decision: D first unless fetch is being forced; nothing granted in reset.
    always_comb begin
        d_gnt = rst & d_req & ~force_i;
        i_gnt = rst & i_req & ~d_gnt;
    end

    // Steer the winning port onto the memory; idle drives a harmless word read of address 0.
    always_comb begin
        mem_WE        = 1'b0;
        mem_MemSize   = SIZE_WORD;
        mem_MemSigned = 1'b0;
        mem_A         = {SIZE_LOG2{1'b0}};
        mem_WD        = 32'h0000_0000;
        if (d_gnt) begin
            mem_WE        = d_we;
            mem_MemSize   = d_size;
            mem_MemSigned = d_signed;
            mem_A         = d_addr;
            mem_WD        = d_wdata;
        end else if (i_gnt) begin
            mem_A = i_addr;
        end else begin
            mem_A = {SIZE_LOG2{1'b0}};
        end
    end

    // Response-owner FSM and rvalid flags, tracking who gets next cycle's read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_owner  <= NONE;
            i_rvalid_r <= 1'b0;
            d_rvalid_r <= 1'b0;
        end else begin
            i_rvalid_r <= i_gnt & ~i_flush;
            d_rvalid_r <= is_load(d_gnt, d_we);
            if (i_gnt) begin
                rsp_owner <= IFETCH;
            end else if (is_load(d_gnt, d_we)) begin
                rsp_owner <= DLOAD;
            end else begin
                rsp_owner <= NONE;
            end
        end
    end

    // Route memory read data to its owner; a flush in the response cycle hides the fetch.
    always_comb begin
        i_rvalid = i_rvalid_r & ~i_flush;
        d_rvalid = d_rvalid_r;
        i_rdata  = 32'h0000_0000;
        d_rdata  = 32'h0000_0000;
        case (rsp_owner)
            IFETCH:  i_rdata = mem_RD;
            DLOAD:   d_rdata = mem_RD;
            NONE:    i_rdata = 32'h0000_0000;
            default: d_rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural byte-lane memory.
module tb_mem_arbiter;

    localparam int SZ = 13;

    logic          clk;
    logic          rst;
    logic          i_req;
    logic [SZ-1:0] i_addr;
    logic          i_flush;
    logic          i_gnt;
    logic          i_rvalid;
    logic [31:0]   i_rdata;
    logic          d_req;
    logic          d_we;
    logic [1:0]    d_size;
    logic          d_signed;
    logic [SZ-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          mem_WE;
    logic [1:0]    mem_MemSize;
    logic          mem_MemSigned;
    logic [SZ-1:0] mem_A;
    logic [31:0]   mem_WD;
    logic [31:0]   mem_RD;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem_arr [0:8191];

    mem_arbiter #(.SIZE_LOG2(SZ), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_WE(mem_WE), .mem_MemSize(mem_MemSize), .mem_MemSigned(mem_MemSigned),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_RD(mem_RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Little-endian sized read, wrapping within the address space.
    function automatic logic [31:0] mread(input logic [SZ-1:0] a, input logic [1:0] sz, input logic sg);
        logic [7:0] b0, b1, b2, b3;
        b0 = mem_arr[a];
        b1 = mem_arr[a + 13'd1];
        b2 = mem_arr[a + 13'd2];
        b3 = mem_arr[a + 13'd3];
        case (sz)
            2'b00:   return sg ? {{24{b0[7]}}, b0} : {24'h0, b0};
            2'b01:   return sg ? {{16{b1[7]}}, b1, b0} : {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    // Behavioural memory: preload in reset, 1-cycle synchronous read, write at the edge.
    always @(posedge clk) begin
        if (!rst) begin
            mem_arr[13'h040] <= 8'h13;
            mem_arr[13'h041] <= 8'h00;
            mem_arr[13'h042] <= 8'h00;
            mem_arr[13'h043] <= 8'h00;
            mem_arr[13'h103] <= 8'h80;
            mem_RD <= 32'h0;
        end else begin
            mem_RD <= mread(mem_A, mem_MemSize, mem_MemSigned);
            if (mem_WE) begin
                for (int k = 0; k < 4; k++) begin
                    if (k < ((mem_MemSize == 2'b00) ? 1 : (mem_MemSize == 2'b01) ? 2 : 4))
                        mem_arr[mem_A + 13'(k)] <= mem_WD[8*k +: 8];
                end
            end
        end
    end

    // Requesters must hold their request until granted.
    a_i_hold: assert property (@(posedge clk) disable iff (!rst) (i_req && !i_gnt) |=> i_req);
    a_d_hold: assert property (@(posedge clk) disable iff (!rst) (d_req && !d_gnt) |=> d_req);

    typedef struct {
        logic          i_req;
        logic [SZ-1:0] i_addr;
        logic          i_flush;
        logic          d_req;
        logic          d_we;
        logic [1:0]    d_size;
        logic          d_signed;
        logic [SZ-1:0] d_addr;
        logic [31:0]   d_wdata;
        logic          e_i_gnt;
        logic          e_d_gnt;
        logic          e_we;
        logic [SZ-1:0] e_a;
        logic          e_i_rv;
        logic [31:0]   e_i_rd;
        logic          e_d_rv;
        logic [31:0]   e_d_rd;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [SZ-1:0] ia, input logic fl,
                         input logic dr, input logic we, input logic [1:0] sz,
                         input logic sg, input logic [SZ-1:0] da, input logic [31:0] wd);
        i_req = ir; i_addr = ia; i_flush = fl;
        d_req = dr; d_we = we; d_size = sz; d_signed = sg; d_addr = da; d_wdata = wd;
    endtask

    initial begin
        // Inputs of each row are applied after a falling edge; response columns refer to the previous row.
        vecs[0]  = '{1'b0,13'h000,1'b0, 1'b1,1'b0,2'b00,1'b1,13'h103,32'h0,        1'b0,1'b1,1'b0,13'h103, 1'b0,32'h0,        1'b0,32'h0};
        vecs[1]  = '{1'b0,13'h000,1'b0, 1'b1,1'b0,2'b00,1'b0,13'h103,32'h0,        1'b0,1'b1,1'b0,13'h103, 1'b0,32'h0,        1'b1,32'hFFFFFF80};
        vecs[2]  = '{1'b0,13'h000,1'b0, 1'b1,1'b1,2'b10,1'b0,13'h100,32'hDEADBEEF, 1'b0,1'b1,1'b1,13'h100, 1'b0,32'h0,        1'b1,32'h00000080};
        vecs[3]  = '{1'b0,13'h000,1'b0, 1'b1,1'b0,2'b10,1'b0,13'h100,32'h0,        1'b0,1'b1,1'b0,13'h100, 1'b0,32'h0,        1'b0,32'h0};
        vecs[4]  = '{1'b1,13'h040,1'b0, 1'b0,1'b0,2'b10,1'b0,13'h000,32'h0,        1'b1,1'b0,1'b0,13'h040, 1'b0,32'h0,        1'b1,32'hDEADBEEF};
        vecs[5]  = '{1'b0,13'h000,1'b1, 1'b0,1'b0,2'b10,1'b0,13'h000,32'h0,        1'b0,1'b0,1'b0,13'h000, 1'b0,32'h00000013, 1'b0,32'h0};
        vecs[6]  = '{1'b1,13'h040,1'b1, 1'b0,1'b0,2'b10,1'b0,13'h000,32'h0,        1'b1,1'b0,1'b0,13'h040, 1'b0,32'h0,        1'b0,32'h0};
        vecs[7]  = '{1'b0,13'h000,1'b0, 1'b0,1'b0,2'b10,1'b0,13'h000,32'h0,        1'b0,1'b0,1'b0,13'h000, 1'b0,32'h00000013, 1'b0,32'h0};
        vecs[8]  = '{1'b0,13'h000,1'b0, 1'b1,1'b0,2'b01,1'b1,13'h102,32'h0,        1'b0,1'b1,1'b0,13'h102, 1'b0,32'h0,        1'b0,32'h0};
        vecs[9]  = '{1'b0,13'h000,1'b0, 1'b0,1'b0,2'b10,1'b0,13'h000,32'h0,        1'b0,1'b0,1'b0,13'h000, 1'b0,32'h0,        1'b1,32'hFFFFDEAD};
        vecs[10] = '{1'b1,13'h040,1'b0, 1'b1,1'b0,2'b10,1'b0,13'h100,32'h0,        1'b0,1'b1,1'b0,13'h100, 1'b0,32'h0,        1'b0,32'h0};
        vecs[11] = '{1'b1,13'h040,1'b0, 1'b0,1'b0,2'b10,1'b0,13'h000,32'h0,        1'b1,1'b0,1'b0,13'h040, 1'b0,32'h0,        1'b1,32'hDEADBEEF};
        vecs[12] = '{1'b0,13'h000,1'b0, 1'b0,1'b0,2'b10,1'b0,13'h000,32'h0,        1'b0,1'b0,1'b0,13'h000, 1'b1,32'h00000013, 1'b0,32'h0};
        vecs[13] = '{1'b0,13'h000,1'b0, 1'b0,1'b0,2'b10,1'b0,13'h000,32'h0,        1'b0,1'b0,1'b0,13'h000, 1'b0,32'h0,        1'b0,32'h0};

        // Reset with both ports requesting: nothing may be granted or written.
        rst = 1'b0;
        drive(1'b1, 13'h040, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 13'h200, 32'h12345678);
        @(negedge clk); #1;
        check("rst_i_gnt", 32'(i_gnt), 32'd0);
        check("rst_d_gnt", 32'(d_gnt), 32'd0);
        check("rst_mem_we", 32'(mem_WE), 32'd0);
        check("rst_i_rvalid", 32'(i_rvalid), 32'd0);
        check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_d_gnt", 32'(d_gnt), 32'd1);
        check("rel_i_gnt", 32'(i_gnt), 32'd0);
        check("rel_mem_we", 32'(mem_WE), 32'd1);
        @(negedge clk);
        d_req = 1'b0; #1;
        check("rel2_i_gnt", 32'(i_gnt), 32'd1);
        check("rel2_mem_a", 32'(mem_A), 32'h040);
        check("rel2_mem_we", 32'(mem_WE), 32'd0);
        @(negedge clk);
        i_req = 1'b0; #1;
        check("rel3_i_rvalid", 32'(i_rvalid), 32'd1);
        check("rel3_i_rdata", i_rdata, 32'h00000013);
        check("rel3_d_rvalid", 32'(d_rvalid), 32'd0);

        // Table-driven vectors.
        for (int v = 0; v < 14; v++) begin
            @(negedge clk);
            drive(vecs[v].i_req, vecs[v].i_addr, vecs[v].i_flush, vecs[v].d_req, vecs[v].d_we,
                  vecs[v].d_size, vecs[v].d_signed, vecs[v].d_addr, vecs[v].d_wdata);
            #1;
            check($sformatf("v%0d_i_gnt", v), 32'(i_gnt), 32'(vecs[v].e_i_gnt));
            check($sformatf("v%0d_d_gnt", v), 32'(d_gnt), 32'(vecs[v].e_d_gnt));
            check($sformatf("v%0d_mem_we", v), 32'(mem_WE), 32'(vecs[v].e_we));
            check($sformatf("v%0d_mem_a", v), 32'(mem_A), 32'(vecs[v].e_a));
            check($sformatf("v%0d_i_rvalid", v), 32'(i_rvalid), 32'(vecs[v].e_i_rv));
            check($sformatf("v%0d_i_rdata", v), i_rdata, vecs[v].e_i_rd);
            check($sformatf("v%0d_d_rvalid", v), 32'(d_rvalid), 32'(vecs[v].e_d_rv));
            check($sformatf("v%0d_d_rdata", v), d_rdata, vecs[v].e_d_rd);
        end

        // Starvation: D streams loads, I waits; I is forced on the fifth cycle.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            drive((c <= 4), 13'h040, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 13'h100, 32'h0);
            #1;
            check($sformatf("st%0d_d_gnt", c), 32'(d_gnt), 32'(c != 4));
            check($sformatf("st%0d_i_gnt", c), 32'(i_gnt), 32'(c == 4));
            if (c == 4) check("st4_d_rdata", d_rdata, 32'hDEADBEEF);
            if (c == 5) begin
                check("st5_i_rvalid", 32'(i_rvalid), 32'd1);
                check("st5_i_rdata", i_rdata, 32'h00000013);
                check("st5_d_rvalid", 32'(d_rvalid), 32'd0);
            end
        end
        @(negedge clk);
        drive(1'b0, 13'h000, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 13'h000, 32'h0);

        // Reset mid-response with the streak at its limit.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(1'b1, 13'h040, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 13'h100, 32'h0);
            #1;
            check($sformatf("rm%0d_d_gnt", c), 32'(d_gnt), 32'd1);
        end
        @(negedge clk); #1;
        check("rm_pending_d_rvalid", 32'(d_rvalid), 32'd1);
        check("rm_pending_streak", 32'(dut.u_starve.streak), 32'd4);
        rst = 1'b0; #1;
        check("rm_rst_d_rvalid", 32'(d_rvalid), 32'd0);
        check("rm_rst_d_gnt", 32'(d_gnt), 32'd0);
        check("rm_rst_i_gnt", 32'(i_gnt), 32'd0);
        check("rm_rst_streak", 32'(dut.u_starve.streak), 32'd0);
        @(negedge clk);
        rst = 1'b1; #1;
        check("rm_rel_d_gnt", 32'(d_gnt), 32'd1);
        check("rm_rel_i_gnt", 32'(i_gnt), 32'd0);
        @(negedge clk);
        d_req = 1'b0; #1;
        check("rm_rel_i_gnt2", 32'(i_gnt), 32'd1);
        @(negedge clk);
        i_req = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
